serial_to_parallel_rx: RTL
==========================

# serial_to_parallel_rx

Receive end of the PHY serial link. Deserializes the 1-bit MSB-first stream produced by the parallel-to-serial transmitter on `clk_8f`. It aligns to byte boundaries using the idle/comma byte 0xBC and declares the link active after a run of aligned idle bytes. It then presents each received non-idle byte as a parallel word with a byte-rate valid level.

## Interface
Parameters:
- `IDLE_BYTE`, default 8'hBC: comma/idle byte sent by the transmitter when it has no valid data.
- `BC_COUNT`, default 4: number of consecutive aligned `IDLE_BYTE`s required to declare the link active. Legal range is 2..15.

Ports:
- `clk_8f`, input, 1: bit-rate clock, the only clock. Every register updates on its rising edge.
- `reset`, input, 1: synchronous, active-low. While low, all state and outputs are forced to their reset values at the next `clk_8f` edge.
- `data_in`, input, 1: serial bit, MSB of each byte first.
- `data_out`, output, 8: last received non-idle byte.
- `valid_out`, output, 1: high while `data_out` holds the most recent byte and that byte was not `IDLE_BYTE`.
- `active`, output, 1: link synchronized.

## Operation
- Shift register `sr[7:0]` updates as `sr <= {sr[6:0], data_in}` every cycle.
- Window `w = {sr[6:0], data_in}` is combinational and holds the 8 most recent bits including the current one.
- Bit counter `bit_cnt[2:0]` and idle counter `bc_cnt[3:0]` are internal.
- States:
  - SEARCH: entered on reset.
    - `bit_cnt` is unused.
    - When `w == IDLE_BYTE`: go to ALIGN, set `bit_cnt <= 0` and `bc_cnt <= 1`.
    - Otherwise remain in SEARCH.
  - ALIGN:
    - `bit_cnt` increments each cycle and wraps 7 -> 0.
    - At `bit_cnt == 7`, where `w` is the next complete byte:
      - If `w == IDLE_BYTE`: `bc_cnt <= bc_cnt + 1`. If `bc_cnt + 1 == BC_COUNT`, go to SYNC and set `active <= 1`.
      - If `w != IDLE_BYTE`: go to SEARCH and set `bc_cnt <= 0`. The window is not rechecked in that same cycle.
  - SYNC:
    - `bit_cnt` continues to wrap.
    - At `bit_cnt == 7`:
      - If `w != IDLE_BYTE`: `data_out <= w` and `valid_out <= 1`.
      - If `w == IDLE_BYTE`: `valid_out <= 0`. `data_out` keeps its previous value.
    - Outputs are unchanged at any other `bit_cnt`.
    - SYNC is left only via reset. There is no loss-of-sync detection in this block.
- `active` is 1 exactly in SYNC.

## Timing
- Reset values: `data_out = 8'h00`, `valid_out = 0`, `active = 0`, `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state SEARCH.
- Reset is sampled at every edge and has priority over everything else. A reset low in any state for one edge returns the block to SEARCH with all outputs at their reset values after that edge.
- Latency: `data_out` and `valid_out` register on the same edge that samples the 8th (LSB) bit of a byte, and are visible immediately after that edge.
- `valid_out` is a level, stable for 8 `clk_8f` cycles, then reevaluated at the next byte boundary.
- `active` rises on the edge sampling the LSB of the `BC_COUNT`-th consecutive aligned idle byte. With `BC_COUNT = 4` this is 32 cycles after the first idle byte's MSB, when the stream is aligned from the start.
- The first data byte after sync is output 8 cycles after `active` rises, at the earliest.
- Arbitrary bit offset: SEARCH checks `w` on every cycle, so alignment is reached with any number of leading garbage bits.
- Back-to-back bytes need no gap cycles; throughput is one byte per 8 cycles.

## Test plan
- Reset: hold `reset = 0` for 3 cycles while driving random `data_in`. Required: `data_out = 00`, `valid_out = 0`, `active = 0` throughout and after release.
- Clean sync: release reset, send 4× 0xBC MSB-first. Required: `active = 1` right after the 32nd bit, and `valid_out = 0`.
- Data after sync: continue with 0xA5, 0x3C, then 0xBC. Required:
  - `data_out = A5`, `valid_out = 1` after bit 40, held 8 cycles.
  - `data_out = 3C` after bit 48.
  - `valid_out = 0` after bit 56, with `data_out` still 3C.
- Misaligned start: send 3 bits `101`, then 4× 0xBC, then 0x5A. Required: `active` rises after bit 35, and `data_out = 5A` with `valid_out = 1` after bit 43.
- Broken preamble: send 3× 0xBC, 0x11, then 4× 0xBC. Required: `active` stays 0 through 0x11, the block returns to SEARCH, and `active` rises only at the end of the second run.
- Reset mid-operation: sync, then assert reset for 1 edge during a data byte. Required: all outputs return to reset values, and resync needs a full `BC_COUNT` idle run.

Source files
------------

// File: rtl/serial_to_parallel_rx_if.sv
// Serial link bundle between the transmitter side and the receive deserializer.
//   data_in   : serial bit, MSB of each byte first (driven by master)
//   data_out  : last received non-idle byte (driven by slave)
//   valid_out : data_out holds the most recent byte and it was not idle
//   active    : receiver is byte-aligned and synchronized
// master = stream source / consumer of the parallel word; slave = receiver.
interface serial_to_parallel_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Receive end of the serial PHY link. Deserializes an MSB-first bit stream, aligns to byte
// boundaries on the idle/comma byte, declares the link active after BC_COUNT consecutive
// aligned idle bytes, then presents each non-idle byte as a parallel word with a byte-rate
// valid level.
// Ports:
//   clk_8f : bit-rate clock, rising edge
//   reset  : synchronous, active-low
//   link   : slave side of serial_to_parallel_rx_if (data_in, data_out, valid_out, active)
// BC_COUNT legal range is 2..15.
module serial_to_parallel_rx #(
  parameter logic [7:0]  IDLE_BYTE = 8'hBC,
  parameter int unsigned BC_COUNT  = 4
) (
  input logic                      clk_8f,
  input logic                      reset,
  serial_to_parallel_rx_if.slave   link
);

  localparam logic [3:0] BcTarget = 4'(BC_COUNT);

  typedef enum logic [1:0] {StSearch, StAlign, StSync} state_e;

  state_e     state_q, state_d;
  // Only the 7 newest bits are ever needed: the window adds the current bit on top.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  logic [7:0] win;
  logic       win_idle;

  assign win      = {sr_q, link.data_in};
  assign win_idle = (win == IDLE_BYTE);

  always_comb begin
    state_d   = state_q;
    sr_d      = win[6:0];
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;

    unique case (state_q)
      StSearch: begin
        // Sliding search: any bit offset can lock here.
        if (win_idle) begin
          state_d   = StAlign;
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
        end
      end

      StAlign: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (win_idle) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_q + 4'd1 == BcTarget) begin
              state_d = StSync;
            end
          end else begin
            // Broken idle run: restart the search from the next bit.
            state_d  = StSearch;
            bc_cnt_d = 4'd0;
          end
        end
      end

      StSync: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (win_idle) begin
            valid_d = 1'b0;
          end else begin
            data_d  = win;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StSearch;
      end
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state_q   <= StSearch;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign link.data_out  = data_q;
  assign link.valid_out = valid_q;
  assign link.active    = (state_q == StSync);

endmodule
